// File: rtl/seg_bus_if.sv
// Bundles the seven-segment pins and the recovered-value outputs.
// master drives the pins and observes the result; slave is the receiver.
interface seg_bus_if;
  logic [6:0]  seg_in;
  logic [3:0]  an_in;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  digit_err;
  logic        stale;

  modport master (
    output seg_in, an_in,
    input  value, valid, digit_err, stale
  );

  modport slave (
    input  seg_in, an_in,
    output value, valid, digit_err, stale
  );
endinterface

// File: rtl/seg_bus_receiver.sv
// Recovers a 4-digit hex value from a multiplexed active-low 7-segment bus.
//
// state  | meaning
// -------+--------------------------------------------------------------
// SETTLE | bus moving; waiting for STABLE_CYCLES identical samples
// HOLD   | current digit captured; waiting for the bus to change again
module seg_bus_receiver #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic      clk,
  input logic      rst_n,
  seg_bus_if.slave bus
);

  localparam int SCW = $clog2(STABLE_CYCLES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SCW-1:0] STAB_MAX  = SCW'(STABLE_CYCLES);
  localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);
  localparam logic [TCW-1:0] TMO_MAX   = TCW'(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {SETTLE, HOLD} state_t;

  logic [10:0]    sync_q1;
  logic [10:0]    sync_q2;

  logic           same;
  logic           an_legal;
  logic [1:0]     an_idx;
  logic [3:0]     an_onehot;
  logic [3:0]     glyph_nib;
  logic           glyph_bad;
  logic           capture;
  logic           complete;
  logic           tmo_hit;
  logic [3:0]     seen_cap;
  logic [15:0]    frame_val;
  logic [3:0]     frame_err;

  state_t         state;
  logic [SCW-1:0] stab_cnt;
  logic [TCW-1:0] tmo_cnt;
  logic [3:0]     seen;
  logic [15:0]    slot_val;
  logic [3:0]     slot_err;
  logic [15:0]    value_q;
  logic           valid_q;
  logic [3:0]     err_q;
  logic           stale_q;

  // Two-flop synchronizer for the 11 asynchronous pin bits {an, seg}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {bus.an_in, bus.seg_in};
      sync_q2 <= sync_q1;
    end
  end

  // Anode decode: exactly one low bit selects a digit, anything else is ignored.
  always_comb begin
    an_legal = 1'b1;
    an_idx   = 2'd0;
    case (sync_q2[10:7])
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_legal = 1'b0;
    endcase
    an_onehot = 4'b0001 << an_idx;
  end

  // Glyph decode, bit 6 = g .. bit 0 = a, active low.
  always_comb begin
    glyph_bad = 1'b0;
    glyph_nib = 4'h0;
    case (sync_q2[6:0])
      7'b1000000: glyph_nib = 4'h0;
      7'b1111001: glyph_nib = 4'h1;
      7'b0100100: glyph_nib = 4'h2;
      7'b0110000: glyph_nib = 4'h3;
      7'b0011001: glyph_nib = 4'h4;
      7'b0010010: glyph_nib = 4'h5;
      7'b0000010: glyph_nib = 4'h6;
      7'b1111000: glyph_nib = 4'h7;
      7'b0000000: glyph_nib = 4'h8;
      7'b0010000: glyph_nib = 4'h9;
      7'b0001000: glyph_nib = 4'hA;
      7'b0000011: glyph_nib = 4'hB;
      7'b1000110: glyph_nib = 4'hC;
      7'b0100001: glyph_nib = 4'hD;
      7'b0000110: glyph_nib = 4'hE;
      7'b0001110: glyph_nib = 4'hF;
      default:    glyph_bad = 1'b1;
    endcase
  end

  // Capture/completion decisions. stab_cnt counts how long the value now in
  // sync_q2 has held, so it is judged against the sample arriving in sync_q1;
  // this puts the capture STABLE_CYCLES edges after the pins move.
  always_comb begin
    same      = (sync_q1 == sync_q2);
    capture   = (state == SETTLE) && same && an_legal && (stab_cnt == STAB_LAST);
    seen_cap  = seen | (capture ? an_onehot : 4'b0000);
    complete  = capture && (seen_cap == 4'hF);
    tmo_hit   = !complete && (tmo_cnt == TMO_LAST);
    frame_val = slot_val;
    frame_err = slot_err;
    if (capture) begin
      frame_val[4*an_idx +: 4] = glyph_nib;
      frame_err[an_idx]        = glyph_bad;
    end
  end

  // Settle/hold FSM with digit slots, frame publication and the stale timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SETTLE;
      stab_cnt <= '0;
      tmo_cnt  <= '0;
      seen     <= 4'b0000;
      slot_val <= 16'h0000;
      slot_err <= 4'b0000;
      value_q  <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 4'b0000;
      stale_q  <= 1'b1;
    end else begin
      valid_q <= complete;

      if (!same) begin
        stab_cnt <= SCW'(1);
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + SCW'(1);
      end

      case (state)
        SETTLE: if (capture) state <= HOLD;
        HOLD:   if (!same)   state <= SETTLE;
        default:             state <= SETTLE;
      endcase

      if (capture) begin
        slot_val <= frame_val;
        slot_err <= frame_err;
      end

      if (complete) begin
        value_q <= frame_val;
        err_q   <= frame_err;
        seen    <= 4'b0000;
        tmo_cnt <= '0;
        stale_q <= 1'b0;
      end else begin
        // A timeout drops partial digits, but a capture on the same edge still counts.
        seen <= tmo_hit ? (capture ? an_onehot : 4'b0000) : seen_cap;
        if (tmo_cnt != TMO_MAX) begin
          tmo_cnt <= tmo_cnt + TCW'(1);
        end
        if (tmo_hit) begin
          stale_q <= 1'b1;
        end
      end
    end
  end

  assign bus.value     = value_q;
  assign bus.valid     = valid_q;
  assign bus.digit_err = err_q;
  assign bus.stale     = stale_q;

endmodule

// File: tb/tb_seg_bus_receiver.sv
// Bench for seg_bus_receiver: directed scenarios plus random pin dwells,
// checked every cycle against a dwell-based reference model.
module tb_seg_bus_receiver;

  localparam int STABLE = 4;
  localparam int TMO    = 50;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] BLANK_SEG = 7'b1111111;
  localparam logic [3:0] BLANK_AN  = 4'b1111;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  seg_bus_if bus ();

  seg_bus_receiver #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // pending capture announced by the driver
  logic       pend_v = 1'b0;
  int         pend_edge = 0;
  int         pend_idx = 0;
  logic [3:0] pend_nib = 4'h0;
  logic       pend_bad = 1'b0;

  // reference model state
  int          cyc = 0;
  logic [3:0]  m_nib [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0]  m_bad = 4'b0000;
  logic [3:0]  m_seen = 4'b0000;
  logic [15:0] m_value = 16'h0000;
  logic [3:0]  m_err = 4'b0000;
  logic        m_valid = 1'b0;
  logic        m_stale = 1'b1;
  int          m_tcnt = 0;
  int          vcount = 0;

  function automatic logic [4:0] glyph_lookup(input logic [6:0] s);
    for (int j = 0; j < 16; j++) begin
      if (GLYPH[j] == s) return {1'b0, 4'(j)};
    end
    return 5'h10;
  endfunction

  task automatic model_step();
    logic       cap;
    logic       done;
    logic [3:0] bit_i;
    if (!rst_n) begin
      m_seen  = 4'b0000;
      m_value = 16'h0000;
      m_err   = 4'b0000;
      m_valid = 1'b0;
      m_stale = 1'b1;
      m_tcnt  = 0;
      return;
    end
    cyc++;
    cap   = pend_v && (cyc == pend_edge);
    done  = 1'b0;
    bit_i = 4'b0000;
    if (cap) begin
      bit_i = 4'(1 << pend_idx);
      m_nib[pend_idx] = pend_nib;
      m_bad[pend_idx] = pend_bad;
      done = ((m_seen | bit_i) == 4'hF);
    end
    if (done) begin
      m_value = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      m_err   = m_bad;
      m_seen  = 4'b0000;
      m_tcnt  = 0;
      m_stale = 1'b0;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
      if (m_tcnt < TMO) begin
        m_tcnt++;
        if (m_tcnt == TMO) begin
          m_stale = 1'b1;
          m_seen  = 4'b0000;
        end
      end
      m_seen = m_seen | bit_i;
    end
  endtask

  // Reference model advances on every DUT edge.
  always begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Count valid pulses a little after each edge.
  always begin
    @(posedge clk);
    #1;
    if (bus.valid === 1'b1) vcount++;
  end

  // Compare all outputs to the model every cycle.
  always begin
    @(negedge clk);
    if (rst_n) begin
      check_eq("cyc_valid", 32'(bus.valid), 32'(m_valid));
      check_eq("cyc_stale", 32'(bus.stale), 32'(m_stale));
      check_eq("cyc_value", 32'(bus.value), 32'(m_value));
      check_eq("cyc_err",   32'(bus.digit_err), 32'(m_err));
    end
  end

  // Called at a falling edge: put a pattern on the pins and hold it n cycles.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    logic [4:0] g;
    int         idx;
    bus.an_in  = a;
    bus.seg_in = s;
    pend_v     = 1'b0;
    if (n >= STABLE + 1 && $countones(~a) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
      g         = glyph_lookup(s);
      pend_idx  = idx;
      pend_nib  = g[3:0];
      pend_bad  = g[4];
      pend_edge = cyc + 1 + STABLE;
      pend_v    = 1'b1;
    end
    repeat (n) @(negedge clk);
  endtask

  int         v0;
  logic [3:0] ra;
  logic [6:0] rs;
  int         rn;
  int         r;

  initial begin
    bus.an_in  = BLANK_AN;
    bus.seg_in = BLANK_SEG;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_value", 32'(bus.value), 32'h0);
    check_eq("rst_valid", 32'(bus.valid), 32'h0);
    check_eq("rst_err",   32'(bus.digit_err), 32'h0);
    check_eq("rst_stale", 32'(bus.stale), 32'h1);

    drive(BLANK_AN, BLANK_SEG, 3);

    // clean scan 1,2,3,4
    v0 = vcount;
    drive(4'b0111, GLYPH[1], 10);
    drive(4'b1011, GLYPH[2], 10);
    drive(4'b1101, GLYPH[3], 10);
    drive(4'b1110, GLYPH[4], 10);
    check_eq("scan_pulses", 32'(vcount - v0), 32'd1);
    check_eq("scan_value",  32'(bus.value), 32'h1234);
    check_eq("scan_err",    32'(bus.digit_err), 32'h0);
    check_eq("scan_stale",  32'(bus.stale), 32'h0);

    // glitch on digit 0 must not replace the captured 8
    drive(4'b1110, GLYPH[8], 8);
    drive(4'b1110, BLANK_SEG, 2);
    drive(4'b1110, GLYPH[8], 2);
    drive(4'b0111, GLYPH[5], 8);
    drive(4'b1011, GLYPH[6], 8);
    drive(4'b1101, GLYPH[7], 8);
    check_eq("glitch_value", 32'(bus.value), 32'h5678);
    check_eq("glitch_err",   32'(bus.digit_err), 32'h0);

    // illegal anodes with three digits pending
    drive(4'b1101, GLYPH[5], 6);
    drive(4'b1110, GLYPH[6], 6);
    drive(4'b0111, GLYPH[7], 6);
    v0 = vcount;
    drive(4'b0011, GLYPH[0], 20);
    check_eq("illegal_multi", 32'(vcount - v0), 32'd0);
    drive(BLANK_AN, BLANK_SEG, 20);
    check_eq("illegal_blank", 32'(vcount - v0), 32'd0);
    check_eq("illegal_stale", 32'(bus.stale), 32'h1);

    // bad glyph in digit 2
    v0 = vcount;
    drive(4'b0111, GLYPH[10], 10);
    drive(4'b1011, BLANK_SEG, 10);
    drive(4'b1101, GLYPH[11], 10);
    drive(4'b1110, GLYPH[13], 10);
    check_eq("bad_pulses", 32'(vcount - v0), 32'd1);
    check_eq("bad_value",  32'(bus.value), 32'hA0BD);
    check_eq("bad_err",    32'(bus.digit_err), 32'h4);

    // timeout discards partial frame
    drive(4'b0111, GLYPH[1], 8);
    drive(4'b1011, GLYPH[2], 8);
    drive(4'b1101, GLYPH[3], 8);
    drive(BLANK_AN, BLANK_SEG, 60);
    check_eq("tmo_stale", 32'(bus.stale), 32'h1);
    v0 = vcount;
    drive(4'b1110, GLYPH[6], 8);
    check_eq("tmo_discard", 32'(vcount - v0), 32'd0);
    drive(4'b0111, GLYPH[9], 8);
    drive(4'b1011, GLYPH[8], 8);
    drive(4'b1101, GLYPH[7], 8);
    check_eq("tmo_pulses", 32'(vcount - v0), 32'd1);
    check_eq("tmo_value",  32'(bus.value), 32'h9876);
    check_eq("tmo_stale2", 32'(bus.stale), 32'h0);

    // asynchronous reset mid-frame
    drive(4'b0111, GLYPH[1], 8);
    drive(4'b1011, GLYPH[2], 8);
    bus.an_in  = BLANK_AN;
    bus.seg_in = BLANK_SEG;
    pend_v     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_value", 32'(bus.value), 32'h0);
    check_eq("arst_valid", 32'(bus.valid), 32'h0);
    check_eq("arst_err",   32'(bus.digit_err), 32'h0);
    check_eq("arst_stale", 32'(bus.stale), 32'h1);
    #2 rst_n = 1'b1;
    @(negedge clk);
    v0 = vcount;
    drive(4'b1101, GLYPH[3], 8);
    drive(4'b1110, GLYPH[4], 8);
    drive(BLANK_AN, BLANK_SEG, 10);
    check_eq("arst_no_frame", 32'(vcount - v0), 32'd0);
    check_eq("arst_stale2",   32'(bus.stale), 32'h1);

    // random dwells
    for (int i = 0; i < 300; i++) begin
      do begin
        r = $urandom_range(0, 9);
        if (r < 7) ra = ~(4'b0001 << $urandom_range(0, 3));
        else       ra = 4'($urandom);
        if ($urandom_range(0, 3) != 0) rs = GLYPH[$urandom_range(0, 15)];
        else                           rs = 7'($urandom);
      end while ({ra, rs} == {bus.an_in, bus.seg_in});
      r  = $urandom_range(0, 9);
      rn = (r < 2) ? r + 1 : r + 3;
      drive(ra, rs, rn);
    end
    drive(BLANK_AN, BLANK_SEG, 10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
